// File: rtl/risc_pkg.sv
// Shared core package: loader sync byte, loader state encoding, checksum helper
// and the opcode/type constants already used by the core.
package risc_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE   = 3'd0,
        LD_LEN_HI = 3'd1,
        LD_LEN_LO = 3'd2,
        LD_DATA   = 3'd3,
        LD_CSUM   = 3'd4,
        LD_DONE   = 3'd5,
        LD_ERR    = 3'd6
    } loader_state_e;

    // Primary opcode field [31:26] of the core's instruction word
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_MAC   = 6'h03;
    localparam logic [5:0] OPC_ADDI  = 6'h0A;
    localparam logic [5:0] OPC_HALT  = 6'h3F;

    localparam logic [1:0] TYPE_R = 2'd0;
    localparam logic [1:0] TYPE_I = 2'd1;
    localparam logic [1:0] TYPE_J = 2'd2;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic state_is_ready(input loader_state_e s);
        logic r;
        case (s)
            LD_IDLE, LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_CSUM: r = 1'b1;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/risc_word_pack.sv
// Byte-to-word packer: shifts bytes MSB-first and strobes when the 4th byte of a word arrives.
module risc_word_pack
    import risc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_r;
    logic [1:0]  cnt_r;

    // Hold the three most recent bytes and count position within the word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_r <= 24'd0;
            cnt_r   <= 2'd0;
        end else if (byte_valid) begin
            shift_r <= {shift_r[15:0], byte_data};
            cnt_r   <= cnt_r + 2'd1;
        end
    end

    assign word       = {shift_r, byte_data};
    assign word_valid = byte_valid && (cnt_r == 2'd3);

endmodule

// File: rtl/risc_prog_loader.sv
// Byte-stream program loader: parses A5/length/words frames into core word memory.
// Define RISC_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module risc_prog_loader
    import risc_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_run,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned MAX_WORDS = MEM_DEPTH - BASE_ADDR;
    localparam logic [9:0]  BASE_W    = 10'(BASE_ADDR);

    loader_state_e state_r, state_next;
    logic          ready_r;
    logic [7:0]    len_hi_r;
    logic [15:0]   len_r;
    logic [9:0]    word_idx_r;
    logic          accept_s;
    logic          pack_valid_s;
    logic [15:0]   len_s;
    logic          len_ok_s;
    logic          last_word_s;
    logic [31:0]   word_s;
    logic          word_valid_s;
`ifdef RISC_LOADER_CHECKSUM_EN
    logic [7:0]    csum_r;
`endif

    assign accept_s     = s_valid && ready_r;
    assign pack_valid_s = accept_s && (state_r == LD_DATA);
    assign len_s        = {len_hi_r, s_data};
    assign len_ok_s     = (len_s != 16'd0) && ({16'd0, len_s} <= 32'(MAX_WORDS));
    assign last_word_s  = ({6'd0, word_idx_r} == (len_r - 16'd1));
    assign s_ready      = ready_r;

    risc_word_pack u_pack (
        .clk        (clk1),
        .rst_n      (rst_n),
        .byte_valid (pack_valid_s),
        .byte_data  (s_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Next-state decode for the frame parser
    always_comb begin
        state_next = state_r;
        case (state_r)
            LD_IDLE: begin
                if (accept_s && (s_data == LOADER_SYNC)) state_next = LD_LEN_HI;
                else                                     state_next = LD_IDLE;
            end
            LD_LEN_HI: begin
                if (accept_s) state_next = LD_LEN_LO;
                else          state_next = LD_LEN_HI;
            end
            LD_LEN_LO: begin
                if (accept_s) state_next = len_ok_s ? LD_DATA : LD_ERR;
                else          state_next = LD_LEN_LO;
            end
            LD_DATA: begin
                if (word_valid_s && last_word_s) begin
`ifdef RISC_LOADER_CHECKSUM_EN
                    state_next = LD_CSUM;
`else
                    state_next = LD_DONE;
`endif
                end else begin
                    state_next = LD_DATA;
                end
            end
`ifdef RISC_LOADER_CHECKSUM_EN
            LD_CSUM: begin
                if (accept_s) state_next = (s_data == csum_r) ? LD_DONE : LD_ERR;
                else          state_next = LD_CSUM;
            end
`endif
            LD_DONE: state_next = LD_DONE;
            LD_ERR:  state_next = LD_ERR;
            default: state_next = LD_ERR;
        endcase
    end

    // State, length and word-index registers; ready tracks the state being entered
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_r    <= LD_IDLE;
            ready_r    <= 1'b0;
            len_hi_r   <= 8'd0;
            len_r      <= 16'd0;
            word_idx_r <= 10'd0;
        end else begin
            state_r <= state_next;
            ready_r <= state_is_ready(state_next);
            if (accept_s && (state_r == LD_LEN_HI)) len_hi_r <= s_data;
            if (accept_s && (state_r == LD_LEN_LO)) len_r <= len_s;
            if (word_valid_s) word_idx_r <= word_idx_r + 10'd1;
        end
    end

`ifdef RISC_LOADER_CHECKSUM_EN
    // Running XOR over every accepted data byte
    always_ff @(posedge clk1) begin
        if (!rst_n) csum_r <= 8'd0;
        else if (pack_valid_s) csum_r <= csum_update(csum_r, s_data);
    end
`endif

    // Registered memory write port and sticky status outputs
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= 10'd0;
            mem_wdata <= 32'd0;
            core_run  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            mem_we <= word_valid_s;
            if (word_valid_s) begin
                mem_addr  <= BASE_W + word_idx_r;
                mem_wdata <= word_s;
            end
            core_run  <= (state_next == LD_DONE);
            load_done <= (state_next == LD_DONE);
            load_err  <= (state_next == LD_ERR);
        end
    end

endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed self-checking bench for risc_prog_loader; adapts to RISC_LOADER_CHECKSUM_EN.
module tb_risc_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_run;
    logic        load_done;
    logic        load_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    logic [31:0] prog [0:8] = '{32'h2801000A, 32'h28020014, 32'h2803001E, 32'h0CE77800,
                                32'h0CE77800, 32'h00222000, 32'h0CE77800, 32'h00832800,
                                32'hFC000000};

    always #5 clk1 = ~clk1;

    risc_prog_loader dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_run  (core_run),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always @(negedge clk1) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap);
        int tries;
        repeat (gap) @(negedge clk1);
        @(negedge clk1);
        s_valid = 1'b1;
        s_data  = b;
        tries   = 0;
        while (!s_ready && tries < 20) begin
            @(negedge clk1);
            tries++;
        end
        check_eq("s_ready_wait", {31'd0, s_ready}, 32'd1);
        if (s_ready) begin
            @(posedge clk1);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic drive_word(input logic [31:0] w, input bit rnd);
        for (int k = 0; k < 4; k++)
            drive_byte(w[31-8*k -: 8], rnd ? int'($urandom_range(0, 5)) : 0);
    endtask

    task automatic send_frame(input int n, input bit rnd);
        logic [15:0] len;
        logic [7:0]  cs;
        len = 16'(n);
        cs  = 8'd0;
        drive_byte(8'hA5, 0);
        drive_byte(len[15:8], rnd ? int'($urandom_range(0, 5)) : 0);
        drive_byte(len[7:0], rnd ? int'($urandom_range(0, 5)) : 0);
        for (int i = 0; i < n; i++) begin
            drive_word(prog[i], rnd);
            cs = cs ^ prog[i][31:24] ^ prog[i][23:16] ^ prog[i][15:8] ^ prog[i][7:0];
        end
`ifdef RISC_LOADER_CHECKSUM_EN
        drive_byte(cs, 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk1);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk1);
        check_eq("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_core_run", {31'd0, core_run}, 32'd0);
        check_eq("rst_load_done", {31'd0, load_done}, 32'd0);
        check_eq("rst_load_err", {31'd0, load_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
        check_eq("rst_ready_after", {31'd0, s_ready}, 32'd1);
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_writes(input string tag, input int n);
        repeat (3) @(negedge clk1);
        check_eq({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check_eq({tag, "_addr"}, {22'd0, wr_addr[i]}, 32'(i));
            check_eq({tag, "_data"}, wr_data[i], prog[i]);
        end
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err);
        check_eq({tag, "_done"}, {31'd0, load_done}, {31'd0, done});
        check_eq({tag, "_run"}, {31'd0, core_run}, {31'd0, done});
        check_eq({tag, "_err"}, {31'd0, load_err}, {31'd0, err});
        check_eq({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;

        // Full nine-word program
        do_reset();
        send_frame(9, 1'b0);
        check_writes("prog", 9);
        check_flags("prog", 1'b1, 1'b0);

        // Leading junk discarded, single word
        do_reset();
        drive_byte(8'h00, 0);
        drive_byte(8'hFF, 0);
        drive_byte(8'hA5, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h01, 0);
        drive_word(32'hDEADBEEF, 1'b0);
`ifdef RISC_LOADER_CHECKSUM_EN
        drive_byte(8'h22, 0);
`endif
        repeat (3) @(negedge clk1);
        check_eq("junk_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) begin
            check_eq("junk_addr", {22'd0, wr_addr[0]}, 32'd0);
            check_eq("junk_data", wr_data[0], 32'hDEADBEEF);
        end
        check_flags("junk", 1'b1, 1'b0);

        // Zero length rejected
        do_reset();
        drive_byte(8'hA5, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h00, 0);
        check_writes("len0", 0);
        check_flags("len0", 1'b0, 1'b1);

        // Length one past memory size rejected
        do_reset();
        drive_byte(8'hA5, 0);
        drive_byte(8'h04, 0);
        drive_byte(8'h01, 0);
        check_writes("len1025", 0);
        check_flags("len1025", 1'b0, 1'b1);

`ifdef RISC_LOADER_CHECKSUM_EN
        // Checksum good and bad
        do_reset();
        drive_byte(8'hA5, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h01, 0);
        drive_word(32'h01020304, 1'b0);
        drive_byte(8'h04, 0);
        repeat (3) @(negedge clk1);
        check_flags("csum_ok", 1'b1, 1'b0);

        do_reset();
        drive_byte(8'hA5, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h01, 0);
        drive_word(32'h01020304, 1'b0);
        drive_byte(8'h05, 0);
        repeat (3) @(negedge clk1);
        check_eq("csum_bad_nwr", 32'(wr_addr.size()), 32'd1);
        check_flags("csum_bad", 1'b0, 1'b1);
`endif

        // Reset mid-frame after 2nd byte of word 3, then fresh two-word frame
        do_reset();
        drive_byte(8'hA5, 0);
        drive_byte(8'h00, 0);
        drive_byte(8'h09, 0);
        drive_word(prog[0], 1'b0);
        drive_word(prog[1], 1'b0);
        drive_byte(prog[2][31:24], 0);
        drive_byte(prog[2][23:16], 0);
        check_eq("abort_pre_nwr", 32'(wr_addr.size()), 32'd2);
        do_reset();
        send_frame(2, 1'b0);
        check_writes("abort", 2);
        check_flags("abort", 1'b1, 1'b0);

        // Same program with random stream gaps
        do_reset();
        send_frame(9, 1'b1);
        check_writes("gaps", 9);
        check_flags("gaps", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_prog_loader.md
RISC_PROG_LOADER -- requirements
Module: risc_prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 0: first memory word address written.
REQ-002 Parameter MEM_DEPTH, default 1024: number of addressable 32-bit words.
REQ-003 clk1  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 s_valid  input  1  byte-stream valid.
REQ-006 s_data  input  8  byte-stream data.
REQ-007 s_ready  output  1  byte-stream ready; a byte is accepted when s_valid and s_ready are both high on a clk1 edge.
REQ-008 mem_we  output  1  one-cycle write strobe into the core's unified word memory.
REQ-009 mem_addr  output  10  word address for mem_we.
REQ-010 mem_wdata  output  32  word data for mem_we.
REQ-011 core_run  output  1  high releases the core from halt; drives the core's HALTED clear and PC=0.
REQ-012 load_done  output  1  frame loaded successfully; sticky.
REQ-013 load_err  output  1  frame rejected; sticky.

Function
REQ-014 Frame format: sync byte 0xA5; length N as 16-bit big-endian; N words of 4 bytes each, big-endian; optional checksum byte (REQ-030).
REQ-015 FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
REQ-016 IDLE: accepted 0xA5 -> LEN_HI; any other accepted byte is discarded and the FSM stays in IDLE.
REQ-017 LEN_HI -> LEN_LO on acceptance. LEN_LO -> DATA on acceptance if 1 <= N <= MEM_DEPTH-BASE_ADDR, else -> ERR.
REQ-018 s_ready = 1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM; s_ready = 0 in DONE and ERR.
REQ-019 DATA: a 2-bit byte counter shifts bytes MSB-first into a 32-bit word; on the 4th accepted byte, mem_we=1 with mem_addr=BASE_ADDR+word_index and mem_wdata=assembled word on the next cycle (latency 1), then word_index increments.
REQ-020 After word N is accepted: -> CSUM when RISC_LOADER_CHECKSUM_EN is defined, else -> DONE.
REQ-021 Word index is 10 bits; it never wraps, because REQ-017 bounds N.
REQ-022 s_valid low stalls the FSM with no state change; bytes may arrive with arbitrary gaps.
REQ-023 DONE: load_done=1, core_run=1, both held until reset.
REQ-024 ERR: load_err=1, core_run=0, both held until reset; words already written stay in memory.
REQ-025 mem_we is never asserted outside the cycle following a 4th data byte.

Reset
REQ-026 When rst_n=0 at a clk1 edge: FSM -> IDLE; counters and checksum -> 0; s_ready=0 during reset; mem_we=0; mem_addr=0; mem_wdata=0; core_run=0; load_done=0; load_err=0.
REQ-027 Reset mid-frame aborts the frame. A write strobe scheduled for the following cycle is cancelled, and the next frame starts from sync.
REQ-028 s_ready=1 on the first cycle after rst_n returns high.

Configuration
REQ-029 Macro RISC_LOADER_CHECKSUM_EN selects the checksum feature.
REQ-030 Defined: CSUM accepts one byte and compares it with the XOR of all 4N data bytes. Match -> DONE; mismatch -> ERR.
REQ-031 Undefined: the CSUM state, the checksum register and the compare logic are absent; the last data word goes directly to DONE.

Structure
REQ-032 Shared package risc_pkg holds: LOADER_SYNC = 8'hA5, the loader state enum, and the opcode/type constants already used by the core.
REQ-033 One sub-module, risc_word_pack: byte-to-word shift register plus 2-bit byte counter, with an output strobe on word complete.

Verification
REQ-034 Frame A5 00 09 followed by the 9 words 2801000A, 28020014, 2803001E, 0CE77800, 0CE77800, 00222000, 0CE77800, 00832800, FC000000 -> 9 mem_we pulses at addr 0..8 with exactly those data, then load_done=1 and core_run=1.
REQ-035 Bytes 00 FF A5 00 01 DE AD BE EF -> leading 00 and FF discarded; a single write of DEADBEEF at addr 0.
REQ-036 Length 00 00, and separately length 04 01 (1025) -> load_err=1, no mem_we, s_ready=0.
REQ-037 Checksum enabled, word 01020304: checksum 04 -> DONE; checksum 05 -> ERR with core_run=0.
REQ-038 rst_n pulsed low after the 2nd byte of word 3, then a fresh 2-word frame -> writes land at addr 0..1, and all outputs were at reset values during reset.
REQ-039 Random s_valid gaps of 0-5 cycles on the REQ-034 frame -> identical memory contents and identical final flags.
